modmul_seq: RTL
===============

// Module: modmul_seq
// PURPOSE
//  Sequential bit-serial modular multiplier for the RSA datapath. It computes either plain x*y mod n
//  (interleaved, MSB-first) or the Montgomery product x*y*2^-NBITS mod n (LSB-first), selected per operation.
//  Width is a parameter, and the block has start/busy/done handshaking and operand error detection.
//  It is the multiply engine called repeatedly by the modular-exponentiation controller.
// PARAMETERS
//  NBITS   256   operand/modulus width in bits (>=4)
//  CNT_W   $clog2(NBITS+1)   iteration counter width (derived, do not override)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only when busy=0
//  mode    in   1      0 = interleaved x*y mod n; 1 = Montgomery x*y*2^-NBITS mod n
//  x       in   NBITS  multiplier, any value < 2^NBITS
//  y       in   NBITS  multiplicand, must be < n
//  n       in   NBITS  modulus; nonzero; odd when mode=1
//  busy    out  1      high from the edge after start is accepted until the edge that raises done
//  done    out  1      one-cycle pulse; out/err valid in that cycle and held until the next accept
//  err     out  1      operand error for the completed request
//  out     out  NBITS  result, fully reduced (< n)
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream): state=IDLE; busy=0, done=0, err=0, out=0.
//    All internal registers clear.
//  - States: IDLE, CALC, FIX, ERR.
//  - IDLE, start=1, edge E0: latch x, y, n, mode. Clear P (NBITS+2 bits). Load counter.
//    Check the operands and go to ERR if any of these holds: n==0, y>=n, or mode=1 with n[0]==0.
//    Otherwise go to CALC. busy=1 from E0.
//  - CALC: one iteration per edge for exactly NBITS edges (E1..E_NBITS).
//    mode0, i = NBITS-1 down to 0:
//      P = 2P; if P>=n then P -= n
//      if x[i] then P += y
//      if P>=n then P -= n
//    mode1, i = 0 up to NBITS-1:
//      if x[i] then P += y
//      if P odd then P += n
//      P >>= 1
//  - Every intermediate is computed in NBITS+2 bits. No truncation is allowed: the Montgomery sum is < 4n.
//  - FIX at edge E_(NBITS+1): if P>=n then out = P-n, else out = P. done=1, err=0, busy=0. Go to IDLE.
//  - ERR at edge E1: out=0, err=1, done=1, busy=0. Go to IDLE (error latency is 1 edge).
//  - done is high for exactly one cycle. out/err hold until the next accepted start.
//  - start while busy=1 is ignored, with no queuing. start in the same cycle that done=1 is accepted
//    (state is IDLE by then).
//  - Input changes after E0 have no effect: operands are registered.
//  - rst_n low mid-operation: immediate abort. Outputs go to their reset values and no done pulse follows.
//  - Normal latency: done rises NBITS+1 edges after the accepting edge E0.
// STRUCTURE
//  - Package modmul_pkg:
//    - state enum {IDLE, CALC, FIX, ERR}
//    - localparams MODE_PLAIN=1'b0 and MODE_MONT=1'b1
//  - Sub-module modmul_step: purely combinational single iteration with inputs (P, y, n, xbit, mode)
//    and output P_next, in NBITS+2 bits. It is reused by a future radix-4 variant.
//  - modmul_seq holds the FSM, the counter, the operand registers, the FIX subtractor and the error checks.
// TESTING
//  1. NBITS=8, mode0, x=7, y=9, n=13 -> out=11 (0x0B), err=0, done 9 edges after the accept edge,
//     busy high 9 cycles.
//  2. NBITS=8, mode1, x=7, y=9, n=13 -> out=7 (63*256^-1 mod 13); x=1, y=1, n=13 -> out=3.
//  3. NBITS=256, mode0, x=y=0xc22ca5bf...e15b8ca1, n=0xE07122F2...0CCA73E1 -> out equals the golden-model
//     x*y mod n, done at edge 257.
//     Add 1000 random mode0/mode1 vectors against the model.
//  4. Errors, NBITS=8:
//     - mode1, n=12 -> err=1, out=0, done 1 edge after accept.
//     - n=0 -> err=1.
//     - y=13, n=13 -> err=1.
//  5. Start pulsed again at cycles 3 and 5 while busy -> ignored, exactly one done.
//     Then start asserted in the done cycle -> new operation accepted.
//  6. rst_n dropped at CALC iteration 4 -> busy/done/err/out=0 immediately, no done pulse.
//     After release, test 1 still gives out=11.

Source files
------------

// File: rtl/modmul_pkg.sv
// modmul_pkg: shared FSM state type and mode encodings for the modular multiplier
package modmul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, ERR} state_t;
  localparam logic MODE_PLAIN = 1'b0;
  localparam logic MODE_MONT  = 1'b1;
endpackage

// File: rtl/modmul_step.sv
// modmul_step: one combinational iteration (p, y, n, xbit, mode -> p_next), interleaved or Montgomery, in NBITS+2 bits
module modmul_step
  import modmul_pkg::*;
#(
  parameter int NBITS = 256
) (
  input  logic [NBITS+1:0] p,
  input  logic [NBITS-1:0] y,
  input  logic [NBITS-1:0] n,
  input  logic             xbit,
  input  logic             mode,
  output logic [NBITS+1:0] p_next
);
  localparam int W = NBITS + 2;
  logic [W-1:0] ye, ne, d, s0, a0, a1, m1;
  assign ye = {2'b00, y};
  assign ne = {2'b00, n};
  assign d  = p << 1;
  assign s0 = d >= ne ? d - ne : d;
  assign a0 = xbit ? s0 + ye : s0;
  assign a1 = xbit ? p + ye : p;
  assign m1 = a1[0] ? a1 + ne : a1;
  assign p_next = mode == MODE_MONT ? m1 >> 1 : (a0 >= ne ? a0 - ne : a0);
endmodule

// File: rtl/modmul_seq.sv
// modmul_seq: bit-serial x*y mod n (mode 0) or x*y*2^-NBITS mod n (mode 1) with start/busy/done/err handshake
module modmul_seq
  import modmul_pkg::*;
#(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [NBITS-1:0] x,
  input  logic [NBITS-1:0] y,
  input  logic [NBITS-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] out
);
  localparam int CNT_W = $clog2(NBITS + 1);
  state_t state, nxt;
  logic [NBITS-1:0] xr, yr, nr;
  logic             mr;
  logic [NBITS+1:0] p, p_next;
  logic [CNT_W-1:0] cnt;
  logic             bad, xbit;
  assign bad  = n == '0 || y >= n || (mode == MODE_MONT && !n[0]);
  // plain mode walks x from the MSB, Montgomery from the LSB; the register shifts accordingly
  assign xbit = mr == MODE_MONT ? xr[0] : xr[NBITS-1];
  assign busy = state != IDLE;
  modmul_step #(.NBITS(NBITS)) u_step (
    .p(p), .y(yr), .n(nr), .xbit(xbit), .mode(mr), .p_next(p_next)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = start ? (bad ? ERR : CALC) : IDLE;
    else if (state == CALC) nxt = cnt == '0 ? FIX : CALC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xr   <= '0;
      yr   <= '0;
      nr   <= '0;
      mr   <= 1'b0;
      p    <= '0;
      cnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xr  <= x;
          yr  <= y;
          nr  <= n;
          mr  <= mode;
          p   <= '0;
          cnt <= CNT_W'(NBITS - 1);
        end
        CALC: begin
          p   <= p_next;
          xr  <= mr == MODE_MONT ? xr >> 1 : xr << 1;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          out  <= p >= {2'b00, nr} ? NBITS'(p - {2'b00, nr}) : NBITS'(p);
          err  <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          out  <= '0;
          err  <= 1'b1;
          done <= 1'b1;
        end
      endcase
    end
endmodule
